// File: rtl/mcu_controller.sv
// mcu_controller: control unit for a small PIC-style 8-bit microcontroller.
//
// Each instruction takes three cycles: FETCH, DECODE, EXEC. The program ROM
// registers its address, so data for rom_addr shows up on rom_q one cycle later.
// The word is latched into IR at the DECODE edge, and PC is incremented on that
// same edge. The ALU op and mux select are decoded combinationally from IR. The
// write enables are registered: they are computed from rom_q at the DECODE
// edge, so they are high only for the EXEC cycle. SLEEP parks the FSM in HALT
// until reset.
//
// Ports:
//   clk      in   1  clock; all state changes on its rising edge
//   reset    in   1  asynchronous, active-high reset
//   rom_addr out  8  program ROM address (= PC)
//   rom_q    in  14  ROM data, valid one cycle after rom_addr
//   op       out  4  ALU operation (0 add,1 sub,2 and,3 or,4 xor,5 pass,
//                    6 inc,7 dec,8 zero,9 not)
//   sel_lit  out  1  ALU operand mux: 1 = literal, 0 = RAM data
//   literal  out  8  IR[7:0]
//   ram_addr out  7  IR[6:0]
//   load_w   out  1  write alu_q into W (EXEC only)
//   ram_we   out  1  write alu_q into RAM at ram_addr (EXEC only)
//   halted   out  1  high while in HALT
module mcu_controller (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_addr,
  input  logic [13:0] rom_q,
  output logic [3:0]  op,
  output logic        sel_lit,
  output logic [7:0]  literal,
  output logic [6:0]  ram_addr,
  output logic        load_w,
  output logic        ram_we,
  output logic        halted
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpPass = 4'd5;
  localparam logic [3:0] OpInc  = 4'd6;
  localparam logic [3:0] OpDec  = 4'd7;
  localparam logic [3:0] OpZero = 4'd8;
  localparam logic [3:0] OpNot  = 4'd9;

  localparam logic [13:0] SleepWord = 14'h0063;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StHalt   = 2'd3
  } state_e;

  state_e      state;
  logic [7:0]  pc;
  logic [13:0] ir;

  // The decoders look only at IR[13:7]: the class in [13:12], the sub-opcode
  // in [11:8], and the destination bit d in [7].

  // Returns {sel_lit, op}. Any encoding not listed decodes to {0, add}.
  function automatic logic [4:0] dec_alu(input logic [6:0] hi);
    logic [4:0] r;
    r = {1'b0, OpAdd};
    if (hi[6:5] == 2'b11) begin
      case (hi[4:1])
        4'h0:    r = {1'b1, OpPass};  // MOVLW
        4'h8:    r = {1'b1, OpOr};    // IORLW
        4'h9:    r = {1'b1, OpAnd};   // ANDLW
        4'hA:    r = {1'b1, OpXor};   // XORLW
        4'hC:    r = {1'b1, OpSub};   // SUBLW
        4'hE:    r = {1'b1, OpAdd};   // ADDLW
        default: r = {1'b0, OpAdd};
      endcase
    end else if (hi[6:5] == 2'b00) begin
      case (hi[4:1])
        4'h1:    r = hi[0] ? {1'b0, OpZero} : {1'b0, OpAdd};  // CLRF needs d=1
        4'h2:    r = {1'b0, OpSub};   // SUBWF
        4'h3:    r = {1'b0, OpDec};   // DECF
        4'h7:    r = {1'b0, OpAdd};   // ADDWF
        4'h8:    r = {1'b0, OpPass};  // MOVF
        4'h9:    r = {1'b0, OpNot};   // COMF
        4'hA:    r = {1'b0, OpInc};   // INCF
        default: r = {1'b0, OpAdd};
      endcase
    end
    return r;
  endfunction

  // Returns {ram_we, load_w} for the instruction; GOTO, SLEEP and NOP give 0.
  function automatic logic [1:0] dec_writes(input logic [6:0] hi);
    logic [1:0] r;
    r = 2'b00;
    if (hi[6:5] == 2'b11) begin
      case (hi[4:1])
        4'h0, 4'h8, 4'h9, 4'hA, 4'hC, 4'hE: r = 2'b01;
        default:                            r = 2'b00;
      endcase
    end else if (hi[6:5] == 2'b00) begin
      case (hi[4:1])
        4'h1:                               r = hi[0] ? 2'b10 : 2'b00;
        4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hA: r = {hi[0], ~hi[0]};
        default:                            r = 2'b00;
      endcase
    end
    return r;
  endfunction

  logic [4:0] alu_dec;
  logic [1:0] wr_next;
  logic       is_goto;
  logic       is_sleep;

  always_comb begin
    alu_dec  = dec_alu(ir[13:7]);
    wr_next  = dec_writes(rom_q[13:7]);
    is_goto  = (ir[13:11] == 3'b101);
    is_sleep = (ir == SleepWord);
  end

  assign rom_addr = pc;
  assign sel_lit  = alu_dec[4];
  assign op       = alu_dec[3:0];
  assign literal  = ir[7:0];
  assign ram_addr = ir[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StFetch;
      pc     <= 8'd0;
      ir     <= 14'd0;
      load_w <= 1'b0;
      ram_we <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        StFetch: begin
          // The ROM samples rom_addr on this edge.
          load_w <= 1'b0;
          ram_we <= 1'b0;
          state  <= StDecode;
        end
        StDecode: begin
          ir     <= rom_q;
          pc     <= pc + 8'd1;  // wraps 255 -> 0
          // Decoded from the incoming word so the enables line up with EXEC.
          load_w <= wr_next[0];
          ram_we <= wr_next[1];
          state  <= StExec;
        end
        StExec: begin
          load_w <= 1'b0;
          ram_we <= 1'b0;
          if (is_goto) begin
            pc <= ir[7:0];
          end
          if (is_sleep) begin
            halted <= 1'b1;
            state  <= StHalt;
          end else begin
            state <= StFetch;
          end
        end
        StHalt: begin
          load_w <= 1'b0;
          ram_we <= 1'b0;
          halted <= 1'b1;
        end
        default: begin
          load_w <= 1'b0;
          ram_we <= 1'b0;
          state  <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_controller.sv
module tb_mcu_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rom_addr;
  logic [13:0] rom_q;
  logic [3:0]  op;
  logic        sel_lit;
  logic [7:0]  literal;
  logic [6:0]  ram_addr;
  logic        load_w;
  logic        ram_we;
  logic        halted;

  mcu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .op       (op),
    .sel_lit  (sel_lit),
    .literal  (literal),
    .ram_addr (ram_addr),
    .load_w   (load_w),
    .ram_we   (ram_we),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Registered-address program ROM.
  logic [13:0] rom [256];
  always @(posedge clk) rom_q <= rom[rom_addr];

  // Instruction tables: 6-bit opcode -> ALU op.
  logic [5:0] lit_opc  [6] = '{6'h30, 6'h38, 6'h39, 6'h3A, 6'h3C, 6'h3E};
  logic [3:0] lit_op   [6] = '{4'd5, 4'd3, 4'd2, 4'd4, 4'd1, 4'd0};
  logic [5:0] file_opc [6] = '{6'h02, 6'h03, 6'h07, 6'h08, 6'h09, 6'h0A};
  logic [3:0] file_op  [6] = '{4'd1, 4'd7, 4'd0, 4'd5, 4'd9, 4'd6};

  typedef struct packed {
    logic [7:0] rom_addr;
    logic [3:0] op;
    logic       sel_lit;
    logic [7:0] literal;
    logic [6:0] ram_addr;
    logic       load_w;
    logic       ram_we;
    logic       halted;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level meaning of one word.
  function automatic void ref_dec(input logic [13:0] w, output logic [3:0] o,
                                  output logic sl, output logic lw, output logic we,
                                  output logic go, output logic slp);
    o = 4'd0; sl = 1'b0; lw = 1'b0; we = 1'b0; go = 1'b0; slp = 1'b0;
    if (w == 14'h0063) slp = 1'b1;
    else if (w[13:11] == 3'b101) go = 1'b1;
    else if (w[13:7] == 7'b0000011) begin o = 4'd8; we = 1'b1; end
    else begin
      for (int i = 0; i < 6; i++) begin
        if (w[13:8] == lit_opc[i]) begin o = lit_op[i]; sl = 1'b1; lw = 1'b1; end
        if (w[13:8] == file_opc[i]) begin o = file_op[i]; lw = ~w[7]; we = w[7]; end
      end
    end
  endfunction

  function automatic exp_t mk(input logic [7:0] a, input logic [13:0] w, input logic lw,
                              input logic we, input logic h);
    exp_t e;
    logic [3:0] o;
    logic s, l, f, g, z;
    ref_dec(w, o, s, l, f, g, z);
    e.rom_addr = a; e.op = o; e.sel_lit = s; e.literal = w[7:0]; e.ram_addr = w[6:0];
    e.load_w = lw; e.ram_we = we; e.halted = h;
    return e;
  endfunction

  // Expected per-cycle outputs for running the ROM from reset. During FETCH
  // and DECODE of an instruction, IR still holds the previous word.
  task automatic build_expect(input int n_instr, input int halt_cycles);
    logic [13:0] prev, w;
    logic [7:0]  pc, npc;
    logic [3:0]  o;
    logic        s, l, f, g, z;
    prev = 14'h0000;
    pc   = 8'd0;
    for (int n = 0; n < n_instr; n++) begin
      w   = rom[pc];
      npc = pc + 8'd1;
      sbq.push_back(mk(pc, prev, 1'b0, 1'b0, 1'b0));
      sbq.push_back(mk(pc, prev, 1'b0, 1'b0, 1'b0));
      ref_dec(w, o, s, l, f, g, z);
      sbq.push_back(mk(npc, w, l, f, 1'b0));
      if (z) begin
        for (int h = 0; h < halt_cycles; h++) sbq.push_back(mk(npc, w, 1'b0, 1'b0, 1'b1));
        return;
      end
      pc   = g ? w[7:0] : npc;
      prev = w;
    end
  endtask

  // Monitor: one scoreboard entry per clock, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && sbq.size() > 0) begin
      e = sbq.pop_front();
      check("rom_addr", 32'(rom_addr), 32'(e.rom_addr));
      check("op",       32'(op),       32'(e.op));
      check("sel_lit",  32'(sel_lit),  32'(e.sel_lit));
      check("literal",  32'(literal),  32'(e.literal));
      check("ram_addr", 32'(ram_addr), 32'(e.ram_addr));
      check("load_w",   32'(load_w),   32'(e.load_w));
      check("ram_we",   32'(ram_we),   32'(e.ram_we));
      check("halted",   32'(halted),   32'(e.halted));
    end
  end

  // Release lands just after a rising edge, so the next sample sees FETCH.
  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && sbq.size() > 0; i++) @(posedge clk);
    check("drain_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic run_prog(input int n_instr, input int halt_cycles);
    sbq.delete();
    build_expect(n_instr, halt_cycles);
    do_reset();
    drain();
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 14'h0000;
  endtask

  function automatic logic [13:0] rand_instr();
    int k;
    k = $urandom_range(0, 29);
    if (k < 6)       return {lit_opc[$urandom_range(0, 5)], 8'($urandom)};
    else if (k < 12) return {file_opc[$urandom_range(0, 5)], 8'($urandom)};
    else if (k == 12) return {7'b0000011, 7'($urandom)};
    else if (k < 15) return {3'b101, 11'($urandom)};
    else if (k == 15) return 14'h0063;
    else if (k == 16) return 14'h0000;
    else if (k < 20) return 14'($urandom);
    else             return {file_opc[$urandom_range(0, 5)], 8'($urandom)};
  endfunction

  initial begin
    clear_rom();
    // Reset values.
    #2 reset = 1'b1;
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_op",       32'(op),       32'd0);
    check("rst_sel_lit",  32'(sel_lit),  32'd0);
    check("rst_load_w",   32'(load_w),   32'd0);
    check("rst_ram_we",   32'(ram_we),   32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_literal",  32'(literal),  32'd0);

    // MOVLW / ADDWF d=1 / GOTO 0 loop.
    clear_rom();
    rom[0] = 14'h303C;
    rom[1] = 14'h07A0;
    rom[2] = 14'h2800;
    run_prog(7, 0);

    // PC wrap through a NOP at 255.
    clear_rom();
    rom[0] = 14'h28FF;
    run_prog(6, 0);

    // Unknown encoding and all-zero word are NOPs.
    clear_rom();
    rom[0] = 14'h3FFF;
    rom[2] = 14'h3FFF;
    run_prog(4, 0);

    // SLEEP, then leave HALT with reset.
    clear_rom();
    rom[0] = 14'h0063;
    run_prog(1, 6);
    @(negedge clk);
    check("halt_halted",   32'(halted),   32'd1);
    check("halt_rom_addr", 32'(rom_addr), 32'd1);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("halt_rst_halted",   32'(halted),   32'd0);
    check("halt_rst_rom_addr", 32'(rom_addr), 32'd0);

    // Reset in the middle of an EXEC that writes RAM.
    clear_rom();
    rom[0] = 14'h07A0;
    sbq.delete();
    do_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_exec_ram_we", 32'(ram_we), 32'd1);
    check("mid_exec_load_w", 32'(load_w), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_ram_we",   32'(ram_we),   32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    check("abort_op",       32'(op),       32'd0);
    @(posedge clk);
    #1 check("abort_hold_ram_we", 32'(ram_we), 32'd0);

    // Random programs.
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < 256; a++) rom[a] = rand_instr();
      run_prog(40, 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
